// File: rtl/spart_pkg.sv
// Shared types and defaults for the SPART receive path.
package spart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam logic LINE_IDLE = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Receive FIFO with first-word fall-through head; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module spart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spart_rx_ext.sv
// Oversampling serial receiver with 3-sample majority vote and receive FIFO.
// Optional parity bit enabled by defining SPART_RX_PARITY_EN.
module spart_rx_ext
  import spart_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx,
  input  logic                              brg_en,
  input  logic                              rd_en,
  input  logic                              clr_err,
  output logic [DATA_W-1:0]                 databus,
  output logic                              rda,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              frame_err,
  output logic                              overrun_err,
  output logic                              parity_err
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_W);

  localparam logic [TICK_W-1:0] TICK_VOTE0 = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_VOTE1 = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] TICK_VOTE2 = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] TICK_END   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_W - 1);

  if (DATA_W < 5 || DATA_W > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_param_check
    $error("spart_rx_ext: illegal parameter set");
  end

  rx_state_e          state;
  rx_state_e          state_next;
  logic               rx_meta;
  logic               rx_sync;
  logic [TICK_W-1:0]  tick;
  logic [BIT_W-1:0]   bit_idx;
  logic               vote0;
  logic               vote1;
  logic [DATA_W-1:0]  shreg;
  logic               push_req;
  logic               at_decide;
  logic               at_end;
  logic               maj;
  logic               tick_clr_c;
  logic               shift_c;
  logic               bit_inc_c;
  logic               push_c;
  logic               frame_c;
  logic               overrun_ev;
  logic               fifo_full;
  logic               fifo_empty;

  // Two-flop synchronizer, parked at the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= LINE_IDLE;
      rx_sync <= LINE_IDLE;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign at_decide = brg_en & (tick == TICK_VOTE2);
  assign at_end    = brg_en & (tick == TICK_END);
  assign maj       = maj3(vote0, vote1, rx_sync);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (brg_en && (rx_sync == 1'b0)) state_next = ST_START;
      ST_START: begin
        if (at_decide && maj) state_next = ST_IDLE;
        else if (at_end)      state_next = ST_DATA;
      end
      ST_DATA: begin
        if (at_end && (bit_idx == BIT_LAST)) begin
`ifdef SPART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef SPART_RX_PARITY_EN
      ST_PARITY: if (at_end) state_next = ST_STOP;
`endif
      ST_STOP:  if (at_decide) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

`ifdef SPART_RX_PARITY_EN
  logic parity_chk_c;
`endif

  always_comb begin
    tick_clr_c = 1'b0;
    shift_c    = 1'b0;
    bit_inc_c  = 1'b0;
    push_c     = 1'b0;
    frame_c    = 1'b0;
`ifdef SPART_RX_PARITY_EN
    parity_chk_c = 1'b0;
`endif
    case (state)
      ST_IDLE:  tick_clr_c = 1'b1;
      ST_START: tick_clr_c = (at_decide & maj) | at_end;
      ST_DATA: begin
        shift_c    = at_decide;
        bit_inc_c  = at_end;
        tick_clr_c = at_end;
      end
`ifdef SPART_RX_PARITY_EN
      ST_PARITY: begin
        parity_chk_c = at_decide;
        tick_clr_c   = at_end;
      end
`endif
      ST_STOP: begin
        tick_clr_c = at_decide;
        push_c     = at_decide & maj;
        frame_c    = at_decide & ~maj;
      end
      default: tick_clr_c = 1'b1;
    endcase
  end

  // Tick/bit counters, vote samples and the LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick     <= '0;
      bit_idx  <= '0;
      vote0    <= LINE_IDLE;
      vote1    <= LINE_IDLE;
      shreg    <= '0;
      push_req <= 1'b0;
    end else begin
      if (tick_clr_c)  tick <= '0;
      else if (brg_en) tick <= tick + TICK_W'(1);
      if (state != ST_DATA) bit_idx <= '0;
      else if (bit_inc_c)   bit_idx <= bit_idx + BIT_W'(1);
      if (brg_en && (tick == TICK_VOTE0)) vote0 <= rx_sync;
      if (brg_en && (tick == TICK_VOTE1)) vote1 <= rx_sync;
      if (shift_c) shreg <= {maj, shreg[DATA_W-1:1]};
      push_req <= push_c;
    end
  end

  assign overrun_ev = push_req & fifo_full & ~rd_en;

  // Sticky flags: a same-cycle event wins over clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_c    | (frame_err   & ~clr_err);
      overrun_err <= overrun_ev | (overrun_err & ~clr_err);
    end
  end

`ifdef SPART_RX_PARITY_EN
  logic parity_ev;
  assign parity_ev = parity_chk_c & (maj != ((^shreg) ^ 1'(PARITY_ODD)));

  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= parity_ev | (parity_err & ~clr_err);
  end
`else
  assign parity_err = 1'b0;
`endif

  spart_rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (rd_en),
    .wdata (shreg),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count),
    .head  (databus)
  );

  assign rda = ~fifo_empty;

endmodule

// File: tb/tb_spart_rx_ext.sv
// Bench for spart_rx_ext: directed tables plus random frames against a queue model.
module tb_spart_rx_ext;

  localparam int unsigned DW    = 8;
  localparam int unsigned OS    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PODD  = 0;
`ifdef SPART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          brg_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] databus;
  logic          rda;
  logic [2:0]    count;
  logic          frame_err;
  logic          overrun_err;
  logic          parity_err;

  spart_rx_ext #(
    .DATA_W     (DW),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH),
    .PARITY_ODD (PODD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .brg_en      (brg_en),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .databus     (databus),
    .rda         (rda),
    .count       (count),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int brg_div = 1;
  int brg_cnt = 0;
  int t_start = 0;
  int rda_rise = -1;

  logic [DW-1:0] mq[$];
  bit m_ferr = 1'b0;
  bit m_ovr  = 1'b0;
  bit m_perr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rda && rda_rise < 0) rda_rise = cyc;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (brg_cnt + 1 >= brg_div) begin
        brg_cnt = 0;
        brg_en  = 1'b1;
      end else begin
        brg_cnt = brg_cnt + 1;
        brg_en  = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: a good stop pushes unless full, a bad stop only flags.
  task automatic model_frame(input logic [DW-1:0] data, input logic stop, input logic par_ok);
    if (PAR_BUILD && !par_ok) m_perr = 1'b1;
    if (stop) begin
      if (mq.size() < DEPTH) mq.push_back(data);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    check({tag, ".count"}, int'(count), mq.size());
    check({tag, ".rda"}, int'(rda), int'(mq.size() != 0));
    if (mq.size() != 0) check({tag, ".databus"}, int'(databus), int'(mq[0]));
    check({tag, ".frame_err"}, int'(frame_err), int'(m_ferr));
    check({tag, ".overrun_err"}, int'(overrun_err), int'(m_ovr));
    check({tag, ".parity_err"}, int'(parity_err), int'(m_perr));
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (brg_en) k++;
    end
  endtask

  task automatic send_bit(input logic b);
    #1 rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic stop, input logic par_flip);
    logic pbit;
    pbit = (^data) ^ 1'(PODD) ^ par_flip;
    @(posedge clk);
    #1 t_start = cyc;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < int'(DW); i++) send_bit(data[i]);
    if (PAR_BUILD) send_bit(pbit);
    send_bit(stop);
    #1 rx = 1'b1;
    model_frame(data, stop, !par_flip);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    if (mq.size() != 0) check({tag, ".head"}, int'(databus), int'(mq[0]));
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check_all(tag);
  endtask

  task automatic clear_flags();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    rx = 1'b1;
    rd_en = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    check({tag, ".count"}, int'(count), 0);
    check({tag, ".rda"}, int'(rda), 0);
    check({tag, ".databus"}, int'(databus), 0);
    check({tag, ".frame_err"}, int'(frame_err), 0);
    check({tag, ".overrun_err"}, int'(overrun_err), 0);
    check({tag, ".parity_err"}, int'(parity_err), 0);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    int            exp_count;
    logic          exp_ferr;
    logic          exp_ovr;
    logic [DW-1:0] exp_head;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [DW-1:0] d;
    logic          s;
    logic          pf;
    int            npop;

    tbl[0] = '{8'h01, 1'b1, 1, 1'b0, 1'b0, 8'h01};
    tbl[1] = '{8'h02, 1'b1, 2, 1'b0, 1'b0, 8'h01};
    tbl[2] = '{8'h03, 1'b1, 3, 1'b0, 1'b0, 8'h01};
    tbl[3] = '{8'h04, 1'b1, 4, 1'b0, 1'b0, 8'h01};
    tbl[4] = '{8'h05, 1'b1, 4, 1'b0, 1'b1, 8'h01};
    tbl[5] = '{8'h3C, 1'b0, 4, 1'b1, 1'b1, 8'h01};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("reset");

    // 8N1 frame 0xA5, brg_en every clk: latency near 160 clks
    send_frame(8'hA5, 1'b1, 1'b0);
    check_all("a5");
    check("a5.latency_in_range", int'((rda_rise - t_start) >= 150 && (rda_rise - t_start) <= 165), 1);
    pop_check("a5.pop");

    // 3-tick low glitch is rejected, then a real frame still decodes
    @(posedge clk);
    #1 rx = 1'b0;
    wait_ticks(3);
    #1 rx = 1'b1;
    wait_ticks(2 * OS);
    check_all("glitch");
    send_frame(8'h33, 1'b1, 1'b0);
    check_all("after_glitch");
    pop_check("after_glitch.pop");

    // Back-to-back frames into a depth-4 FIFO, then a bad stop bit
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, 1'b0);
      @(negedge clk);
      check($sformatf("tbl%0d.count", i), int'(count), tbl[i].exp_count);
      check($sformatf("tbl%0d.frame_err", i), int'(frame_err), int'(tbl[i].exp_ferr));
      check($sformatf("tbl%0d.overrun_err", i), int'(overrun_err), int'(tbl[i].exp_ovr));
      check($sformatf("tbl%0d.databus", i), int'(databus), int'(tbl[i].exp_head));
    end
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("drain%0d.head", i), int'(databus), i + 1);
      pop_check($sformatf("drain%0d", i));
    end
    pop_check("pop_empty");
    clear_flags();
    check_all("clr_after_table");

    // Frame 0x3C with a low stop bit on an empty FIFO
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(OS);
    check_all("ferr");
    clear_flags();
    check_all("ferr.clr");

    // Reset in the middle of DATA, then a clean frame
    @(posedge clk);
    #1 rx = 1'b0;
    wait_ticks(OS);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset();
    check_reset("midreset");
    wait_ticks(OS);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_ticks(OS);
    check_all("after_reset");
    pop_check("after_reset.pop");

`ifdef SPART_RX_PARITY_EN
    // Even parity: 0x01 with parity bit 0 flags parity but still pushes
    send_frame(8'h01, 1'b1, 1'b1);
    wait_ticks(OS);
    @(negedge clk);
    check("parity.parity_err", int'(parity_err), 1);
    check("parity.count", int'(count), 1);
    check("parity.databus", int'(databus), 8'h01);
    pop_check("parity.pop");
    clear_flags();
    check_all("parity.clr");
`endif

    // Random frames, baud rates, stop bits, reads and clears vs the model
    for (int n = 0; n < 12; n++) begin
      brg_div = int'($urandom_range(1, 3));
      d  = DW'($urandom);
      s  = ($urandom_range(0, 5) != 0);
      pf = PAR_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
      send_frame(d, s, pf);
      wait_ticks(OS);
      check_all($sformatf("rnd%0d", n));
      npop = int'($urandom_range(0, 2));
      for (int k = 0; k < npop; k++) pop_check($sformatf("rnd%0d.pop%0d", n, k));
      if ($urandom_range(0, 3) == 0) begin
        clear_flags();
        check_all($sformatf("rnd%0d.clr", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spart_rx_ext.md
SPART_RX_EXT -- requirements
Module: spart_rx_ext

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, brg_en ticks per bit; legal values: even, at least 8.
REQ-003 Parameter FIFO_DEPTH, default 4, receive FIFO entries; legal values: power of two, at least 2.
REQ-004 Parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only when the parity macro is defined.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 brg_en  input  1  one-clk oversample strobe from the baud generator.
REQ-009 rd_en  input  1  pops the FIFO head.
REQ-010 clr_err  input  1  clears the sticky error flags.
REQ-011 databus  output  DATA_W  FIFO head, first-word fall-through.
REQ-012 rda  output  1  high when the FIFO is not empty.
REQ-013 count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
REQ-014 frame_err, overrun_err, parity_err  output  1 each  sticky error flags.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1. All later logic uses the synchronized value.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP. The tick counter advances only on brg_en.
REQ-017 IDLE->START on a brg_en tick with synchronized rx=0; the tick counter clears on entry.
REQ-018 Bit decision: majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit ends at tick OVERSAMPLE-1.
REQ-019 START: a majority value of 1 SHALL return the FSM to IDLE with no push and no error; otherwise the FSM goes to DATA at the bit end.
REQ-020 DATA: shift in DATA_W bits LSB first; bit 0 lands in databus[0].
REQ-021 STOP: the stop decision is made at tick OVERSAMPLE/2+1.
  - Majority 1: push the word.
  - Majority 0: set frame_err, no push.
  - Either case: the FSM returns to IDLE on the next clk, so a back-to-back start bit is caught.
REQ-022 Push latency: the word is written on the clk edge that follows the stop decision; rda is high on the next cycle.
REQ-023 Push while full: the new word is dropped, overrun_err is set, and FIFO contents are unchanged.
REQ-024 Simultaneous push and rd_en while full: the pop SHALL be honoured and the push accepted; count is unchanged.
REQ-025 rd_en while empty: ignored, and count SHALL NOT underflow.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 If clr_err and an error event occur in the same cycle, the flag SHALL end that cycle set.

Reset
REQ-028 rst SHALL return the block to this state regardless of the FSM state, including mid-frame:
  - FSM in IDLE, tick and bit counters at 0.
  - FIFO empty and pointers at 0.
  - rda=0, count=0, databus=0.
  - All error flags 0.

Configuration
REQ-029 Macro SPART_RX_PARITY_EN, defined: after DATA the FSM enters PARITY and samples one bit. On a mismatch with PARITY_ODD sense it sets parity_err; the word is still pushed.
REQ-030 SPART_RX_PARITY_EN undefined: the PARITY state is unreachable, DATA goes directly to STOP, and parity_err is tied to 0.

Structure
REQ-031 Package spart_pkg SHALL hold:
  - the rx FSM state enum;
  - default constants for DATA_W, OVERSAMPLE and FIFO_DEPTH;
  - the idle line level constant.
REQ-032 The FIFO SHALL be the sub-module spart_rx_fifo, with parameters for width and depth and ports push, pop, full, empty, count and head.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
  - 8N1 frame 0xA5 with brg_en every cycle -> rda=1 about 160 clks later, databus=0xA5, count=1; after rd_en, rda=0.
  - rx low for 3 brg_en ticks, then high -> no push, no error, FSM back in IDLE.
  - 5 frames 0x01..0x05, FIFO_DEPTH=4, no reads -> count=4, overrun_err=1, pops return 0x01..0x04.
  - Frame 0x3C with stop bit 0 -> frame_err=1, count=0; clr_err -> frame_err=0.
  - With SPART_RX_PARITY_EN, PARITY_ODD=0: frame 0x01 with parity bit 0 -> parity_err=1, 0x01 pushed.
  - rst asserted mid-DATA, then frame 0x5A -> only 0x5A received, all flags 0.
